// File: rtl/regbank_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regbank_wb_arbiter_pkg
// Purpose  : Shared widths and writeback request type for the register-bank
//            writeback arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package regbank_wb_arbiter_pkg;

    localparam int unsigned NREGS      = 32;
    localparam int unsigned REG_ADDR_W = $clog2(NREGS);
    localparam int unsigned DATA_W     = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] regAddr;
        logic [DATA_W-1:0]     val;
    } wbReq_t;

endpackage : regbank_wb_arbiter_pkg
`default_nettype wire

// File: rtl/regbank_wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regbank_wb_arbiter_rr_arbiter
// Purpose  : Combinational round-robin grant; the scan starts at i_ptr and
//            wraps modulo NUM_REQ. Produces one-hot and encoded grant.
// Revision : 1.0 - initial release
// ============================================================================
module regbank_wb_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_reqVec,
    input  logic [PTR_W-1:0]   i_ptr,
    input  logic               i_enable,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grantIdx,
    output logic               o_grantValid
);

    localparam int SUM_W = PTR_W + 1;

    logic [SUM_W-1:0] w_sum;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_grant      = '0;
        o_grantIdx   = '0;
        o_grantValid = 1'b0;
        w_sum        = '0;
        w_idx        = '0;
        if (i_enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                // ptr + k never exceeds 2*NUM_REQ-2, so one subtraction wraps it
                w_sum = {1'b0, i_ptr} + SUM_W'(k);
                if (w_sum >= SUM_W'(NUM_REQ)) begin
                    w_sum = w_sum - SUM_W'(NUM_REQ);
                end
                w_idx = w_sum[PTR_W-1:0];
                if (!o_grantValid && i_reqVec[w_idx]) begin
                    o_grant[w_idx] = 1'b1;
                    o_grantIdx     = w_idx;
                    o_grantValid   = 1'b1;
                end
            end
        end
    end

endmodule : regbank_wb_arbiter_rr_arbiter
`default_nettype wire

// File: rtl/regbank_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regbank_wb_arbiter
// Purpose  : Round-robin sharing of the register-bank write port among
//            NUM_REQ writeback sources, with read-port forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module regbank_wb_arbiter
    import regbank_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ZERO_WIRED = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [REG_ADDR_W*NUM_REQ-1:0]  req_reg,
    input  logic [DATA_W*NUM_REQ-1:0]      req_val,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           hold,
    output logic                           wb_sig,
    output logic [REG_ADDR_W-1:0]          wb_reg,
    output logic [DATA_W-1:0]              wb_val,
    input  logic [REG_ADDR_W-1:0]          rd_reg1,
    input  logic [REG_ADDR_W-1:0]          rd_reg2,
    input  logic [DATA_W-1:0]              bank_val1,
    input  logic [DATA_W-1:0]              bank_val2,
    output logic [DATA_W-1:0]              rd_val1,
    output logic [DATA_W-1:0]              rd_val2
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_paramCheck
            $error("regbank_wb_arbiter: NUM_REQ must be in 2..8");
        end
    endgenerate

    wbReq_t                w_reqs [NUM_REQ];
    logic [NUM_REQ-1:0]    w_reqVec;
    logic [NUM_REQ-1:0]    w_grant;
    logic [PTR_W-1:0]      w_grantIdx;
    logic                  w_grantValid;
    logic                  w_arbEnable;
    logic [REG_ADDR_W-1:0] w_selReg;
    logic [DATA_W-1:0]     w_selVal;
    logic                  w_selIssues;

    logic [PTR_W-1:0]      r_rrPtr;
    logic                  r_wbSig;
    logic [REG_ADDR_W-1:0] r_wbReg;
    logic [DATA_W-1:0]     r_wbVal;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_reqs[gi] = '{valid:   req_valid[gi],
                                  regAddr: req_reg[REG_ADDR_W*gi +: REG_ADDR_W],
                                  val:     req_val[DATA_W*gi +: DATA_W]};
            assign w_reqVec[gi] = w_reqs[gi].valid;
        end
    endgenerate

    // Grants are suppressed during reset so no handshake can complete then.
    assign w_arbEnable = !hold && !rst;

    regbank_wb_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rrArbiter (
        .i_reqVec     (w_reqVec),
        .i_ptr        (r_rrPtr),
        .i_enable     (w_arbEnable),
        .o_grant      (w_grant),
        .o_grantIdx   (w_grantIdx),
        .o_grantValid (w_grantValid)
    );

    assign req_ready = w_grant;

    assign w_selReg    = w_reqs[w_grantIdx].regAddr;
    assign w_selVal    = w_reqs[w_grantIdx].val;
    // A register-0 write under ZERO_WIRED still handshakes but never reaches the bank.
    assign w_selIssues = !((ZERO_WIRED != 0) && (w_selReg == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rrPtr <= '0;
            r_wbSig <= 1'b0;
            r_wbReg <= '0;
            r_wbVal <= '0;
        end else if (w_grantValid) begin
            r_rrPtr <= (w_grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : w_grantIdx + 1'b1;
            r_wbSig <= w_selIssues;
            r_wbReg <= w_selReg;
            r_wbVal <= w_selVal;
        end else begin
            r_wbSig <= 1'b0;
        end
    end

    assign wb_sig = r_wbSig;
    assign wb_reg = r_wbReg;
    assign wb_val = r_wbVal;

    assign rd_val1 = (r_wbSig && (r_wbReg == rd_reg1)) ? r_wbVal : bank_val1;
    assign rd_val2 = (r_wbSig && (r_wbReg == rd_reg2)) ? r_wbVal : bank_val2;

endmodule : regbank_wb_arbiter
`default_nettype wire

// File: tb/tb_regbank_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regbank_wb_arbiter
// Purpose  : Directed vector table, reset corner case and randomized run
//            against a behavioural model of the writeback arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_wb_arbiter;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  reqValid;
    logic [5*N-1:0]  reqReg;
    logic [32*N-1:0] reqVal;
    logic [N-1:0]  reqReady;
    logic          hold;
    logic          wbSig;
    logic [4:0]    wbReg;
    logic [31:0]   wbVal;
    logic [4:0]    rdReg1, rdReg2;
    logic [31:0]   bankVal1, bankVal2, rdVal1, rdVal2;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    regbank_wb_arbiter #(.NUM_REQ(N), .ZERO_WIRED(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(reqValid), .req_reg(reqReg), .req_val(reqVal),
        .req_ready(reqReady), .hold(hold),
        .wb_sig(wbSig), .wb_reg(wbReg), .wb_val(wbVal),
        .rd_reg1(rdReg1), .rd_reg2(rdReg2),
        .bank_val1(bankVal1), .bank_val2(bankVal2),
        .rd_val1(rdVal1), .rd_val2(rdVal2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0]  valid;
        logic [4:0]  r0, r1, r2;
        logic [31:0] v0, v1, v2;
        logic        hold;
        logic [4:0]  rd1;
        logic [31:0] bv1;
        logic [4:0]  rd2;
        logic [31:0] bv2;
        logic [2:0]  expReady;
        logic [31:0] expRd1, expRd2;
        logic        expSig;
        logic [4:0]  expReg;
        logic [31:0] expVal;
    } vec_t;

    function automatic vec_t mk(
        logic [2:0] v, logic [4:0] r0, logic [4:0] r1, logic [4:0] r2,
        logic [31:0] v0, logic [31:0] v1, logic [31:0] v2, logic h,
        logic [4:0] rd1, logic [31:0] bv1, logic [4:0] rd2, logic [31:0] bv2,
        logic [2:0] er, logic [31:0] e1, logic [31:0] e2,
        logic es, logic [4:0] erg, logic [31:0] ev);
        vec_t t;
        t.valid = v; t.r0 = r0; t.r1 = r1; t.r2 = r2;
        t.v0 = v0; t.v1 = v1; t.v2 = v2; t.hold = h;
        t.rd1 = rd1; t.bv1 = bv1; t.rd2 = rd2; t.bv2 = bv2;
        t.expReady = er; t.expRd1 = e1; t.expRd2 = e2;
        t.expSig = es; t.expReg = erg; t.expVal = ev;
        return t;
    endfunction

    vec_t vecs [20];

    // Behavioural model state for the randomized phase
    int          mPtr;
    logic        mSig;
    logic [4:0]  mReg;
    logic [31:0] mVal;
    logic [2:0]  pend;
    logic [4:0]  pReg [N];
    logic [31:0] pVal [N];

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        reqValid = '0; hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mPtr = 0; mSig = 1'b0; mReg = '0; mVal = '0; pend = '0;
    endtask

    initial begin
        rst = 1'b1; reqValid = 3'b111; reqReg = '0; reqVal = '0; hold = 1'b0;
        rdReg1 = 5'd31; rdReg2 = 5'd31; bankVal1 = 32'hB1; bankVal2 = 32'hB2;

        vecs[0]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 31, 'hB1, 31, 'hB2, 3'b000, 'hB1, 'hB2, 0, 0, 0);
        vecs[1]  = mk(3'b001, 5, 0, 0, 'hAA, 0, 0, 0, 31, 'hB1, 31, 'hB2, 3'b001, 'hB1, 'hB2, 1, 5, 'hAA);
        vecs[2]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 5, 0, 31, 'hB2, 3'b000, 'hAA, 'hB2, 0, 5, 'hAA);
        vecs[3]  = mk(3'b010, 0, 7, 0, 0, 'h1234, 0, 0, 31, 'hB1, 31, 'hB2, 3'b010, 'hB1, 'hB2, 1, 7, 'h1234);
        vecs[4]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 7, 0, 8, 'h55, 3'b000, 'h1234, 'h55, 0, 7, 'h1234);
        vecs[5]  = mk(3'b100, 0, 0, 9, 0, 0, 'h99, 0, 31, 'hB1, 31, 'hB2, 3'b100, 'hB1, 'hB2, 1, 9, 'h99);
        vecs[6]  = mk(3'b111, 10, 11, 12, 'h100, 'h101, 'h102, 0, 31, 'hB1, 31, 'hB2, 3'b001, 'hB1, 'hB2, 1, 10, 'h100);
        vecs[7]  = mk(3'b111, 10, 11, 12, 'h100, 'h101, 'h102, 0, 10, 0, 31, 'hB2, 3'b010, 'h100, 'hB2, 1, 11, 'h101);
        vecs[8]  = mk(3'b111, 10, 11, 12, 'h100, 'h101, 'h102, 0, 31, 'hB1, 31, 'hB2, 3'b100, 'hB1, 'hB2, 1, 12, 'h102);
        vecs[9]  = mk(3'b111, 10, 11, 12, 'h100, 'h101, 'h102, 0, 31, 'hB1, 31, 'hB2, 3'b001, 'hB1, 'hB2, 1, 10, 'h100);
        vecs[10] = mk(3'b111, 10, 11, 12, 'h100, 'h101, 'h102, 0, 31, 'hB1, 31, 'hB2, 3'b010, 'hB1, 'hB2, 1, 11, 'h101);
        vecs[11] = mk(3'b111, 10, 11, 12, 'h100, 'h101, 'h102, 0, 31, 'hB1, 31, 'hB2, 3'b100, 'hB1, 'hB2, 1, 12, 'h102);
        vecs[12] = mk(3'b010, 0, 0, 0, 0, 'hDEAD, 0, 0, 31, 'hB1, 31, 'hB2, 3'b010, 'hB1, 'hB2, 0, 0, 'hDEAD);
        vecs[13] = mk(3'b101, 13, 0, 14, 'h130, 0, 'h140, 0, 0, 'h77, 31, 'hB2, 3'b100, 'h77, 'hB2, 1, 14, 'h140);
        vecs[14] = mk(3'b001, 13, 0, 0, 'h130, 0, 0, 0, 31, 'hB1, 31, 'hB2, 3'b001, 'hB1, 'hB2, 1, 13, 'h130);
        vecs[15] = mk(3'b100, 0, 0, 15, 0, 0, 'h150, 1, 31, 'hB1, 31, 'hB2, 3'b000, 'hB1, 'hB2, 0, 13, 'h130);
        vecs[16] = vecs[15];
        vecs[17] = vecs[15];
        vecs[18] = mk(3'b100, 0, 0, 15, 0, 0, 'h150, 0, 31, 'hB1, 31, 'hB2, 3'b100, 'hB1, 'hB2, 1, 15, 'h150);
        vecs[19] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 31, 'hB1, 31, 'hB2, 3'b000, 'hB1, 'hB2, 0, 15, 'h150);

        // Reset held: no grant even with every requester valid
        #1;
        check("rst_ready", 32'(reqReady), 32'h0);
        check("rst_wbSig", 32'(wbSig), 32'h0);
        check("rst_wbReg", 32'(wbReg), 32'h0);
        check("rst_wbVal", wbVal, 32'h0);
        @(negedge clk);
        reqValid = '0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            reqValid = vecs[i].valid;
            reqReg   = {vecs[i].r2, vecs[i].r1, vecs[i].r0};
            reqVal   = {vecs[i].v2, vecs[i].v1, vecs[i].v0};
            hold     = vecs[i].hold;
            rdReg1   = vecs[i].rd1; bankVal1 = vecs[i].bv1;
            rdReg2   = vecs[i].rd2; bankVal2 = vecs[i].bv2;
            #1;
            check($sformatf("vec%0d_ready", i), 32'(reqReady), 32'(vecs[i].expReady));
            check($sformatf("vec%0d_rdVal1", i), rdVal1, vecs[i].expRd1);
            check($sformatf("vec%0d_rdVal2", i), rdVal2, vecs[i].expRd2);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_wbSig", i), 32'(wbSig), 32'(vecs[i].expSig));
            check($sformatf("vec%0d_wbReg", i), 32'(wbReg), 32'(vecs[i].expReg));
            check($sformatf("vec%0d_wbVal", i), wbVal, vecs[i].expVal);
        end

        // Asynchronous reset while a write sits in the wb stage
        @(negedge clk);
        reqValid = 3'b010;
        reqReg   = {5'd0, 5'd20, 5'd21};
        reqVal   = {32'h0, 32'h200, 32'h210};
        #1;
        check("mid_ready", 32'(reqReady), 32'b010);
        @(posedge clk);
        #1;
        check("mid_wbSigBefore", 32'(wbSig), 32'h1);
        check("mid_wbRegBefore", 32'(wbReg), 32'd20);
        #1;
        rst = 1'b1;
        #1;
        check("mid_wbSigRst", 32'(wbSig), 32'h0);
        check("mid_wbRegRst", 32'(wbReg), 32'h0);
        check("mid_wbValRst", wbVal, 32'h0);
        check("mid_readyRst", 32'(reqReady), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        reqValid = 3'b111;
        #1;
        check("mid_ptrZero", 32'(reqReady), 32'b001);
        @(posedge clk);
        #1;
        check("mid_wbRegAfter", 32'(wbReg), 32'd21);
        check("mid_wbSigAfter", 32'(wbSig), 32'h1);

        // Randomized phase against the behavioural model
        doReset();
        for (int c = 0; c < 400; c++) begin
            int g;
            logic [2:0]  expReady;
            logic [31:0] e1, e2;
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i] = 1'b1;
                    pReg[i] = 5'($urandom_range(7));
                    pVal[i] = $urandom;
                end
            end
            reqValid = pend;
            reqReg   = {pReg[2], pReg[1], pReg[0]};
            reqVal   = {pVal[2], pVal[1], pVal[0]};
            hold     = ($urandom_range(4) == 0);
            rdReg1   = ($urandom_range(1) == 1) ? mReg : 5'($urandom_range(7));
            rdReg2   = ($urandom_range(1) == 1) ? mReg : 5'($urandom_range(7));
            bankVal1 = $urandom;
            bankVal2 = $urandom;
            #1;
            g = -1;
            if (!hold) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (mPtr + k) % N;
                    if (g < 0 && pend[idx]) g = idx;
                end
            end
            expReady = (g >= 0) ? 3'(1 << g) : 3'b000;
            e1 = (mSig && mReg == rdReg1) ? mVal : bankVal1;
            e2 = (mSig && mReg == rdReg2) ? mVal : bankVal2;
            check("rnd_ready", 32'(reqReady), 32'(expReady));
            check("rnd_wbSig", 32'(wbSig), 32'(mSig));
            check("rnd_wbReg", 32'(wbReg), 32'(mReg));
            check("rnd_wbVal", wbVal, mVal);
            check("rnd_rdVal1", rdVal1, e1);
            check("rnd_rdVal2", rdVal2, e2);
            if (g >= 0) begin
                mReg = pReg[g];
                mVal = pVal[g];
                mSig = (pReg[g] != 5'd0);
                mPtr = (g + 1) % N;
                pend[g] = 1'b0;
            end else begin
                mSig = 1'b0;
            end
            @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule : tb_regbank_wb_arbiter
`default_nettype wire
